dose_alarm: RTL and testbench
=============================

# dose_alarm

Dose scheduler and alarm sequencer for the pill dispenser. It watches the BCD wall-clock time from the chronometer and scans the packed user/medicine schedule table written by the menu controller. When a dose falls due, it queues it, sounds the buzzer, and waits for the patient to confirm. It then issues a one-cycle dispense command carrying the user/medicine index to the servo driver. Runs in the 10 kHz operating-clock domain.

## Interface
- USERS, 4: number of user records (fixed at 4 for this revision)
- MEDS, 4: medicine entries per user (fixed at 4)
- TIMEOUT, 600_000: ring timeout in clk cycles (60 s at 10 kHz)

- clk  in  1  10 kHz operating clock
- reset  in  1  asynchronous, active-high reset
- tiempo_i  in  16  current time, BCD {hour tens, hour units, min tens, min units}
- usuarios_i  in  516  4 records × 129 bits, record u at [129u+128 : 129u]
- ack_i  in  1  patient confirmation, one-cycle pulse from keypad decode
- sonar_o  out  1  buzzer enable
- med_o  out  4  index of active dose {user[1:0], med[1:0]}
- dispense_o  out  1  one-cycle dispense strobe
- missed_o  out  1  one-cycle strobe: dose timed out unconfirmed
- pending_o  out  16  queued doses, bit = user*4+med
- busy_o  out  1  scan in progress

## Operation
- Record layout (relative to record base): bit 0 valid; entry m at [24m+24 : 24m+1] as six BCD digits d0..d5 (d0 at low nibble): d0,d1 = interval hours (tens, units); d2,d3 = start hour; d4,d5 = start minute; bits [128:97] RFID tag (ignored).
- An entry is considered only if the record is valid and the entry is nonzero.
- Minute-change detect: register tiempo_i each cycle; any difference from the previous value requests a scan.
- Scan FSM: S_IDLE → S_LOAD → S_MOD → S_NEXT → (S_LOAD | S_IDLE).
  - S_LOAD: convert hours to binary (tens*10+units); interval I = d0*10+d1, with I>23 treated as 0. If the minute digits differ from the current minute, go to S_NEXT with no match. Otherwise diff = (cur_h − start_h + 24) mod 24.
  - S_MOD: if I==0, match iff diff==0. Otherwise subtract I from diff once per cycle until diff < I; match iff diff==0.
  - S_NEXT: on match, set pending[idx]. idx 15 → S_IDLE, else idx+1.
- A scan request arriving during a scan sets a rescan flag; a second full scan runs immediately after S_IDLE is reached.
- Alarm FSM: A_IDLE → A_RING → A_DISP → A_IDLE.
  - A_IDLE: if pending≠0, select the lowest set index, load med_o, clear that pending bit, and go to A_RING.
  - A_RING: sonar_o=1 and the timeout counter counts. ack_i → A_DISP. Counter reaching TIMEOUT−1 → missed_o pulse, A_IDLE.
  - A_DISP: dispense_o=1 for exactly one cycle, then A_IDLE.
- ack_i outside A_RING is ignored.
- A rescan that matches the entry currently ringing re-sets its pending bit; that entry rings again after the current alarm finishes.
- When the scan FSM sets a pending bit in the same cycle the alarm FSM clears a bit, both take effect. A set of the same bit wins.

## Timing
- Reset values: sonar_o=0, med_o=0, dispense_o=0, missed_o=0, pending_o=0, busy_o=0, previous-time register=16'h0000, both FSMs idle, timeout counter=0.
- At reset, if tiempo_i=16'h0000 no scan starts; any other value starts a scan on the first clock after reset release.
- Scan start occurs 1 cycle after the tiempo_i change. busy_o is high from S_LOAD until S_IDLE.
- Per-entry cost: 3 cycles plus up to 23 S_MOD cycles. Worst-case scan is ≤ 416 cycles, well under one minute.
- Pending bit to sonar_o: 2 cycles (one in A_IDLE, registered output).
- ack_i to dispense_o: 2 cycles. med_o is held stable through A_DISP.
- Reset asserted mid-ring or mid-scan aborts immediately to reset values. No strobe is emitted.

## Configuration
- DOSE_ALARM_TIMEOUT_EN defined: the TIMEOUT counter and missed_o are active as described.
- Not defined: no counter is built and A_RING waits indefinitely for ack_i. missed_o is tied to 0.

## Test plan
- Valid user 0, entry 0 = start 08:30, interval 0. Step tiempo_i 08:29 → 08:30 → pending_o=16'h0001 within 417 cycles, sonar_o=1, med_o=0. Send ack_i → dispense_o pulse 2 cycles later, sonar_o=0.
- User 2, entry 1: start 06:15, interval 8. tiempo_i=22:15 → match (diff 16, 16 mod 8=0), med_o=4'h9. tiempo_i=21:15 → no match.
- Entry 05:00, interval 0. Record valid bit=0 → no match at 05:00. Set valid=1 → match.
- Two entries, idx 3 and idx 12, due at the same minute → pending_o=16'h1008. Idx 3 rings first; idx 12 rings after ack.
- With DOSE_ALARM_TIMEOUT_EN and TIMEOUT=100: no ack → missed_o pulse at cycle 100 of ringing, sonar_o falls. Without the macro, sonar_o is still 1 after 10_000 cycles.
- Assert reset during A_RING → all outputs 0 next edge, pending_o=0. No dispense_o or missed_o.

Source files
------------

// File: rtl/dose_alarm_if.sv
// rtl/dose_alarm_if.sv - Bus bundle between the dispenser controller and dose_alarm
//
// Purpose: groups the clock-time, schedule table, patient confirmation and
// alarm/dispense outputs of dose_alarm into one bundle.
// Signals:
//   tiempo_i    [15:0]  BCD wall-clock time {h tens, h units, m tens, m units}
//   usuarios_i  [515:0] packed schedule, 4 records x 129 bits
//   ack_i               patient confirmation pulse
//   sonar_o             buzzer enable
//   med_o       [3:0]   active dose index {user, med}
//   dispense_o          one-cycle dispense strobe
//   missed_o            one-cycle missed-dose strobe
//   pending_o   [15:0]  queued doses, bit = user*4+med
//   busy_o              schedule scan in progress
// Modports: master drives the inputs of dose_alarm, slave is dose_alarm.

interface dose_alarm_if;
  logic [15:0]  tiempo_i;
  logic [515:0] usuarios_i;
  logic         ack_i;
  logic         sonar_o;
  logic [3:0]   med_o;
  logic         dispense_o;
  logic         missed_o;
  logic [15:0]  pending_o;
  logic         busy_o;

  modport master (
    output tiempo_i, usuarios_i, ack_i,
    input  sonar_o, med_o, dispense_o, missed_o, pending_o, busy_o
  );

  modport slave (
    input  tiempo_i, usuarios_i, ack_i,
    output sonar_o, med_o, dispense_o, missed_o, pending_o, busy_o
  );
endinterface

// File: rtl/dose_alarm.sv
// rtl/dose_alarm.sv - Dose scheduler and alarm sequencer for the pill dispenser
//
// Purpose: watches the BCD wall clock, scans the 16 schedule entries whenever
// the time changes, queues due doses, rings the buzzer for the lowest queued
// dose and issues a one-cycle dispense strobe once the patient confirms.
// Ports:
//   clk    10 kHz operating clock
//   reset  asynchronous, active-high reset
//   bus    dose_alarm_if.slave (tiempo_i, usuarios_i, ack_i in;
//          sonar_o, med_o, dispense_o, missed_o, pending_o, busy_o out)
// Build option: DOSE_ALARM_TIMEOUT_EN enables the TIMEOUT ring counter and
// missed_o; without it the ring waits for ack_i forever and missed_o is 0.

module dose_alarm
`ifdef DOSE_ALARM_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT = 600_000)
`endif
(
  input  logic        clk,
  input  logic        reset,
  dose_alarm_if.slave bus
);

  localparam int USERS = 4;
  localparam int MEDS  = 4;
  localparam int N_ENT = USERS * MEDS;
  localparam int REC_W = 129;
  localparam int ENT_W = 24;

  function automatic logic [7:0] bcd2bin(input logic [3:0] tens, input logic [3:0] units);
    return ({4'd0, tens} * 8'd10) + {4'd0, units};
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MOD, S_NEXT} scan_t;
  typedef enum logic [1:0] {A_IDLE, A_RING, A_DISP} alarm_t;

  scan_t       r_scan, w_scan_nxt;
  alarm_t      r_alarm, w_alarm_nxt;

  logic [15:0] r_prev_time;
  logic        r_rescan;
  logic [3:0]  r_idx;
  logic [7:0]  r_diff;
  logic [4:0]  r_ival;
  logic        r_match;
  logic [15:0] r_pending;
  logic [3:0]  r_med;
  logic        r_sonar;
  logic        r_dispense;

  logic        w_time_chg;
  logic [9:0]  w_rec_base;
  logic [9:0]  w_ent_base;
  logic        w_valid;
  logic [23:0] w_entry;
  logic [7:0]  w_ival_raw;
  logic [4:0]  w_ival;
  logic [7:0]  w_start_h;
  logic [7:0]  w_cur_h;
  logic [7:0]  w_sum;
  logic [7:0]  w_diff;
  logic        w_min_eq;
  logic        w_consider;
  logic        w_last;
  logic        w_mod_done;
  logic [15:0] w_set;
  logic [15:0] w_clr;
  logic [3:0]  w_pick;
  logic        w_have_pending;
  logic        w_timeout;
  logic        w_sonar_d;
  logic        w_disp_d;

  // ---------------- schedule entry decode ----------------
  assign w_time_chg = (bus.tiempo_i != r_prev_time);
  assign w_rec_base = 10'(REC_W) * {8'd0, r_idx[3:2]};
  assign w_ent_base = w_rec_base + 10'(ENT_W) * {8'd0, r_idx[1:0]} + 10'd1;
  assign w_valid    = bus.usuarios_i[w_rec_base];
  assign w_entry    = bus.usuarios_i[w_ent_base +: ENT_W];

  // Intervals beyond 23 h make no sense for a daily schedule; treat as "once a day".
  assign w_ival_raw = bcd2bin(w_entry[3:0], w_entry[7:4]);
  assign w_ival     = (w_ival_raw > 8'd23) ? 5'd0 : w_ival_raw[4:0];
  assign w_start_h  = bcd2bin(w_entry[11:8], w_entry[15:12]);
  assign w_cur_h    = bcd2bin(bus.tiempo_i[15:12], bus.tiempo_i[11:8]);
  // Hours elapsed since the start hour, wrapped into 0..23.
  assign w_sum      = w_cur_h + 8'd24 - w_start_h;
  assign w_diff     = (w_sum >= 8'd24) ? (w_sum - 8'd24) : w_sum;
  assign w_min_eq   = (w_entry[19:16] == bus.tiempo_i[7:4]) &&
                      (w_entry[23:20] == bus.tiempo_i[3:0]);
  assign w_consider = w_valid && (w_entry != 24'd0);
  assign w_last     = (r_idx == 4'(N_ENT - 1));
  assign w_mod_done = (r_ival == 5'd0) || (r_diff < {3'd0, r_ival});

  // ---------------- scan FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_scan <= S_IDLE;
    else       r_scan <= w_scan_nxt;
  end

  always_comb begin
    w_scan_nxt = r_scan;
    case (r_scan)
      S_IDLE:  if (w_time_chg || r_rescan) w_scan_nxt = S_LOAD;
      S_LOAD:  w_scan_nxt = (w_consider && w_min_eq) ? S_MOD : S_NEXT;
      S_MOD:   if (w_mod_done) w_scan_nxt = S_NEXT;
      S_NEXT:  w_scan_nxt = w_last ? S_IDLE : S_LOAD;
      default: w_scan_nxt = S_IDLE;
    endcase
  end

  assign bus.busy_o = (r_scan != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_time <= 16'h0000;
      r_rescan    <= 1'b0;
      r_idx       <= 4'd0;
      r_diff      <= 8'd0;
      r_ival      <= 5'd0;
      r_match     <= 1'b0;
    end else begin
      r_prev_time <= bus.tiempo_i;
      // Leaving S_IDLE always launches a scan, which covers any queued request.
      if (r_scan == S_IDLE)  r_rescan <= 1'b0;
      else if (w_time_chg)   r_rescan <= 1'b1;
      case (r_scan)
        S_LOAD: begin
          r_diff  <= w_diff;
          r_ival  <= w_ival;
          r_match <= 1'b0;
        end
        S_MOD: begin
          // Modulo by repeated subtraction, one step per cycle.
          if (w_mod_done) r_match <= (r_diff == 8'd0);
          else            r_diff  <= r_diff - {3'd0, r_ival};
        end
        S_NEXT:  r_idx <= r_idx + 4'd1;
        default: ;
      endcase
    end
  end

  // ---------------- pending queue ----------------
  assign w_set = (r_scan == S_NEXT && r_match) ? (16'd1 << r_idx) : 16'd0;

  always_comb begin
    w_pick = 4'd0;
    for (int i = N_ENT - 1; i >= 0; i--) begin
      if (r_pending[i]) w_pick = 4'(i);
    end
  end

  assign w_have_pending = |r_pending;
  assign w_clr = (r_alarm == A_IDLE && w_have_pending) ? (16'd1 << w_pick) : 16'd0;

  // Clear first, then set, so a re-match of the dose being taken survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pending <= 16'd0;
    else       r_pending <= (r_pending & ~w_clr) | w_set;
  end

  assign bus.pending_o = r_pending;

  // ---------------- ring timeout ----------------
`ifdef DOSE_ALARM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  logic          r_missed;
  logic          w_missed_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 r_cnt <= '0;
    else if (r_alarm == A_RING) r_cnt <= r_cnt + 1'b1;
    else                       r_cnt <= '0;
  end

  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // ---------------- alarm FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_alarm <= A_IDLE;
    else       r_alarm <= w_alarm_nxt;
  end

  always_comb begin
    w_alarm_nxt = r_alarm;
    case (r_alarm)
      A_IDLE:  if (w_have_pending) w_alarm_nxt = A_RING;
      A_RING: begin
        if (bus.ack_i)      w_alarm_nxt = A_DISP;
        else if (w_timeout) w_alarm_nxt = A_IDLE;
      end
      A_DISP:  w_alarm_nxt = A_IDLE;
      default: w_alarm_nxt = A_IDLE;
    endcase
  end

  // Outputs are registered copies of the current state, so they trail it by one cycle.
  always_comb begin
    w_sonar_d = (r_alarm == A_RING);
    w_disp_d  = (r_alarm == A_DISP);
`ifdef DOSE_ALARM_TIMEOUT_EN
    w_missed_d = (r_alarm == A_RING) && !bus.ack_i && w_timeout;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_med      <= 4'd0;
      r_sonar    <= 1'b0;
      r_dispense <= 1'b0;
    end else begin
      if (r_alarm == A_IDLE && w_have_pending) r_med <= w_pick;
      r_sonar    <= w_sonar_d;
      r_dispense <= w_disp_d;
    end
  end

`ifdef DOSE_ALARM_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_missed <= 1'b0;
    else       r_missed <= w_missed_d;
  end
  assign bus.missed_o = r_missed;
`else
  assign bus.missed_o = 1'b0;
`endif

  assign bus.sonar_o    = r_sonar;
  assign bus.med_o      = r_med;
  assign bus.dispense_o = r_dispense;

endmodule

// File: tb/tb_dose_alarm.sv
// tb/tb_dose_alarm.sv - Scoreboard testbench for dose_alarm

module tb_dose_alarm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dose_alarm_if bus();

`ifdef DOSE_ALARM_TIMEOUT_EN
  dose_alarm #(.TIMEOUT(100)) dut (.clk(clk), .reset(rst), .bus(bus.slave));
`else
  dose_alarm dut (.clk(clk), .reset(rst), .bus(bus.slave));
`endif

  int vectors = 0;
  int miscompares = 0;
  // Expected strobes in order: {is_missed, dose index}.
  logic [4:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [23:0] mk_entry(input int sh, input int sm, input int iv);
    return {4'(sm % 10), 4'(sm / 10), 4'(sh % 10), 4'(sh / 10), 4'(iv % 10), 4'(iv / 10)};
  endfunction

  function automatic logic [15:0] mk_time(input int h, input int m);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic logic [515:0] put(input logic [515:0] tbl, input int idx, input logic [23:0] e);
    logic [515:0] t;
    t = tbl;
    t[129 * (idx / 4)] = 1'b1;
    t[129 * (idx / 4) + 24 * (idx % 4) + 1 +: 24] = e;
    return t;
  endfunction

  function automatic bit due(input logic [515:0] tbl, input int idx, input logic [15:0] t);
    int base, iv, sh, ch, d;
    logic [23:0] e;
    base = 129 * (idx / 4);
    e = tbl[base + 24 * (idx % 4) + 1 +: 24];
    if (!tbl[base] || e == 24'd0) return 1'b0;
    if (e[19:16] != t[7:4] || e[23:20] != t[3:0]) return 1'b0;
    iv = int'(e[3:0]) * 10 + int'(e[7:4]);
    if (iv > 23) iv = 0;
    sh = int'(e[11:8]) * 10 + int'(e[15:12]);
    ch = int'(t[15:12]) * 10 + int'(t[11:8]);
    d = (ch - sh + 24) % 24;
    return (iv == 0) ? (d == 0) : (d % iv == 0);
  endfunction

  function automatic logic [15:0] due_mask(input logic [515:0] tbl, input logic [15:0] t);
    logic [15:0] m;
    m = 16'd0;
    for (int i = 0; i < 16; i++) m[i] = due(tbl, i, t);
    return m;
  endfunction

  function automatic logic [515:0] rand_tbl(input int th, input int tm);
    logic [515:0] tbl;
    int sh, sm, iv;
    tbl = '0;
    for (int u = 0; u < 4; u++) begin
      tbl[129 * u + 97 +: 32] = $urandom;
      for (int m = 0; m < 4; m++) begin
        if ($urandom_range(0, 4) != 0) begin
          sh = ($urandom_range(0, 2) == 0) ? th : int'($urandom_range(0, 23));
          sm = ($urandom_range(0, 3) != 0) ? tm : int'($urandom_range(0, 59));
          iv = int'($urandom_range(0, 25));
          tbl = put(tbl, u * 4 + m, mk_entry(sh, sm, iv));
        end
      end
      tbl[129 * u] = ($urandom_range(0, 3) != 0);
    end
    return tbl;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic [4:0] e;
    forever begin
      @(negedge clk);
      if (!rst && (bus.dispense_o || bus.missed_o)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {30'd0, bus.missed_o, bus.dispense_o}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind_idx", {27'd0, bus.missed_o, bus.med_o}, {27'd0, e});
        end
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.tiempo_i = 16'h0000;
    bus.ack_i = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic wait_scan(input int max);
    int n = 0;
    while (bus.busy_o && n < max) begin
      tick();
      n++;
    end
    check("scan_done", {31'd0, bus.busy_o}, 32'd0);
  endtask

  task automatic wait_sonar(input logic lvl, input int max);
    int n = 0;
    while (bus.sonar_o !== lvl && n < max) begin
      tick();
      n++;
    end
    check("sonar_wait", {31'd0, bus.sonar_o}, {31'd0, lvl});
  endtask

  task automatic pulse_ack();
    bus.ack_i = 1'b1;
    tick();
    bus.ack_i = 1'b0;
  endtask

  task automatic push_mask(input logic [15:0] m);
    for (int i = 0; i < 16; i++) if (m[i]) exp_q.push_back({1'b0, 4'(i)});
  endtask

  // Apply time t after a reset with table tbl, check the queue state, then serve every dose.
  task automatic run_trial(input logic [515:0] tbl, input logic [15:0] t);
    logic [15:0] m;
    int low;
    do_reset();
    bus.usuarios_i = tbl;
    bus.tiempo_i = t;
    m = due_mask(tbl, t);
    push_mask(m);
    tick();
    check("busy_start", {31'd0, bus.busy_o}, 32'd1);
    wait_scan(420);
    repeat (3) tick();
    low = 0;
    for (int i = 15; i >= 0; i--) if (m[i]) low = i;
    if (m != 16'd0) begin
      check("ring_sonar", {31'd0, bus.sonar_o}, 32'd1);
      check("ring_med", {28'd0, bus.med_o}, 32'(low));
      check("pending_rest", {16'd0, bus.pending_o}, {16'd0, m & ~(16'd1 << low)});
    end else begin
      check("idle_sonar", {31'd0, bus.sonar_o}, 32'd0);
      check("idle_pending", {16'd0, bus.pending_o}, 32'd0);
    end
    for (int k = 0; k < $countones(m); k++) begin
      wait_sonar(1'b1, 10);
      repeat ($urandom_range(0, 4)) tick();
      pulse_ack();
      wait_sonar(1'b0, 5);
    end
    repeat (3) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("final_sonar", {31'd0, bus.sonar_o}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [515:0] tbl;
    int h, mi, n;

    bus.tiempo_i = 16'h0000;
    bus.usuarios_i = '0;
    bus.ack_i = 1'b0;
    tick();
    check("rst_sonar", {31'd0, bus.sonar_o}, 32'd0);
    check("rst_med", {28'd0, bus.med_o}, 32'd0);
    check("rst_dispense", {31'd0, bus.dispense_o}, 32'd0);
    check("rst_missed", {31'd0, bus.missed_o}, 32'd0);
    check("rst_pending", {16'd0, bus.pending_o}, 32'd0);
    check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    check("no_scan_at_zero", {31'd0, bus.busy_o}, 32'd0);

    // 08:29 -> 08:30 with exact ack-to-dispense latency.
    do_reset();
    tbl = put('0, 0, mk_entry(8, 30, 0));
    bus.usuarios_i = tbl;
    bus.tiempo_i = mk_time(8, 29);
    tick();
    wait_scan(420);
    repeat (3) tick();
    check("d1_early_pending", {16'd0, bus.pending_o}, 32'd0);
    check("d1_early_sonar", {31'd0, bus.sonar_o}, 32'd0);
    bus.tiempo_i = mk_time(8, 30);
    push_mask(due_mask(tbl, mk_time(8, 30)));
    tick();
    wait_scan(417);
    repeat (3) tick();
    check("d1_sonar", {31'd0, bus.sonar_o}, 32'd1);
    check("d1_med", {28'd0, bus.med_o}, 32'd0);
    pulse_ack();
    check("d1_disp_early", {31'd0, bus.dispense_o}, 32'd0);
    tick();
    check("d1_disp", {31'd0, bus.dispense_o}, 32'd1);
    check("d1_sonar_off", {31'd0, bus.sonar_o}, 32'd0);
    tick();
    check("d1_disp_one_cycle", {31'd0, bus.dispense_o}, 32'd0);
    check("d1_drained", 32'(exp_q.size()), 32'd0);

    // Interval schedule on user 2 entry 1.
    tbl = put('0, 9, mk_entry(6, 15, 8));
    run_trial(tbl, mk_time(22, 15));
    run_trial(tbl, mk_time(21, 15));

    // Valid bit gating.
    tbl = put('0, 4, mk_entry(5, 0, 0));
    tbl[129] = 1'b0;
    run_trial(tbl, mk_time(5, 0));
    tbl[129] = 1'b1;
    run_trial(tbl, mk_time(5, 0));

    // Two simultaneous doses ring lowest first.
    tbl = put(put('0, 3, mk_entry(10, 45, 0)), 12, mk_entry(10, 45, 0));
    run_trial(tbl, mk_time(10, 45));

    // Rescan re-queues the dose that is currently ringing.
    do_reset();
    tbl = put('0, 0, mk_entry(8, 30, 1));
    bus.usuarios_i = tbl;
    bus.tiempo_i = mk_time(8, 30);
    push_mask(due_mask(tbl, mk_time(8, 30)));
    tick();
    wait_scan(420);
    wait_sonar(1'b1, 10);
    bus.tiempo_i = mk_time(9, 30);
    push_mask(due_mask(tbl, mk_time(9, 30)));
    tick();
    wait_scan(420);
    tick();
    check("rescan_pending", {16'd0, bus.pending_o}, 32'h0001);
    for (int k = 0; k < 2; k++) begin
      wait_sonar(1'b1, 10);
      pulse_ack();
      wait_sonar(1'b0, 5);
    end
    repeat (3) tick();
    check("rescan_drained", 32'(exp_q.size()), 32'd0);

    // Unconfirmed ring.
    do_reset();
    tbl = put('0, 0, mk_entry(8, 30, 0));
    bus.usuarios_i = tbl;
    bus.tiempo_i = mk_time(8, 30);
`ifdef DOSE_ALARM_TIMEOUT_EN
    exp_q.push_back(5'b1_0000);
    tick();
    wait_scan(420);
    wait_sonar(1'b1, 10);
    n = 0;
    while (!bus.missed_o && n < 150) begin
      tick();
      n++;
    end
    check("missed_seen", {31'd0, bus.missed_o}, 32'd1);
    check("missed_latency_ok", {31'd0, (n >= 98 && n <= 101)}, 32'd1);
    wait_sonar(1'b0, 3);
`else
    exp_q.push_back(5'b0_0000);
    tick();
    wait_scan(420);
    wait_sonar(1'b1, 10);
    repeat (10_000) tick();
    check("ring_forever", {31'd0, bus.sonar_o}, 32'd1);
    check("no_missed", {31'd0, bus.missed_o}, 32'd0);
    pulse_ack();
    wait_sonar(1'b0, 5);
`endif
    repeat (3) tick();
    check("timeout_drained", 32'(exp_q.size()), 32'd0);

    // Reset while ringing with another dose still queued.
    do_reset();
    tbl = put(put('0, 0, mk_entry(8, 30, 0)), 1, mk_entry(8, 30, 0));
    bus.usuarios_i = tbl;
    bus.tiempo_i = mk_time(8, 30);
    tick();
    wait_scan(420);
    wait_sonar(1'b1, 10);
    check("pre_reset_pending", {16'd0, bus.pending_o}, 32'h0002);
    rst = 1'b1;
    bus.tiempo_i = 16'h0000;
    exp_q.delete();
    tick();
    check("abort_sonar", {31'd0, bus.sonar_o}, 32'd0);
    check("abort_pending", {16'd0, bus.pending_o}, 32'd0);
    check("abort_med", {28'd0, bus.med_o}, 32'd0);
    check("abort_busy", {31'd0, bus.busy_o}, 32'd0);
    rst = 1'b0;
    repeat (20) tick();
    check("abort_quiet", {31'd0, bus.sonar_o}, 32'd0);

    // Randomized tables and times.
    for (int trial = 0; trial < 25; trial++) begin
      h = int'($urandom_range(0, 23));
      mi = int'($urandom_range(0, 59));
      if (h == 0 && mi == 0) mi = 1;
      run_trial(rand_tbl(h, mi), mk_time(h, mi));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
